// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART with a baud tick generator, runtime frame format and TX/RX FIFOs.
// Optional feature macro UART_LOOPBACK_EN adds a `loopback` input that feeds internal tx into the RX path.
module uart_core_param #(
  parameter int FIFO_AW    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DVSR_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        cfg_dbits,
  input  logic [1:0]        cfg_par,
  input  logic              cfg_stop2,
  input  logic              rx,
  input  logic              rd_uart,
  output logic [7:0]        r_data,
  output logic [1:0]        r_err,
  output logic              rx_empty,
  output logic [FIFO_AW:0]  rx_level,
  output logic              rx_overrun,
  input  logic              clr_overrun,
  input  logic [7:0]        w_data,
  input  logic              wr_uart,
  output logic              tx_full,
  output logic [FIFO_AW:0]  tx_level,
  output logic              tx_busy,
  output logic              tx
);

  localparam int SW    = $clog2(2 * OVERSAMPLE);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [SW-1:0]    OS_MID   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]    OS_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0]    OS2_LAST = SW'(2 * OVERSAMPLE - 1);
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // ---------------- baud tick ----------------
  logic [DVSR_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == dvsr);

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + DVSR_W'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]         txf_mem [DEPTH];
  logic [FIFO_AW-1:0] txf_wp, txf_rp;
  logic               txf_empty, txf_wr_ok, txf_rd_ok, tx_pop;
  logic [7:0]         txf_head;

  assign txf_empty = (tx_level == '0);
  assign tx_full   = (tx_level == FULL_LVL);
  assign txf_wr_ok = wr_uart & ~tx_full;
  assign txf_rd_ok = tx_pop & ~txf_empty;
  assign txf_head  = txf_mem[txf_rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      txf_wp   <= '0;
      txf_rp   <= '0;
      tx_level <= '0;
    end else begin
      if (txf_wr_ok) txf_wp <= txf_wp + FIFO_AW'(1);
      if (txf_rd_ok) txf_rp <= txf_rp + FIFO_AW'(1);
      if (txf_wr_ok && !txf_rd_ok)      tx_level <= tx_level + (FIFO_AW+1)'(1);
      else if (!txf_wr_ok && txf_rd_ok) tx_level <= tx_level - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (txf_wr_ok) txf_mem[txf_wp] <= w_data;
  end

  // ---------------- TX FSM ----------------
  logic [2:0]    tx_state, tx_state_n;
  logic [SW-1:0] tx_s, tx_s_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_pbit, tx_pbit_n;
  logic [1:0]    tx_dbits, tx_dbits_n;
  logic          tx_pen, tx_pen_n, tx_stop2, tx_stop2_n;
  logic          tx_reg, tx_reg_n, tx_load;
  logic [7:0]    head_masked;

  assign head_masked = txf_head & (8'hFF >> (2'd3 - cfg_dbits));

  always_comb begin
    tx_state_n = tx_state;
    tx_s_n     = tx_s;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pbit_n  = tx_pbit;
    tx_dbits_n = tx_dbits;
    tx_pen_n   = tx_pen;
    tx_stop2_n = tx_stop2;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    tx_reg_n   = 1'b1;
    case (tx_state)
      S_IDLE: if (!txf_empty) tx_load = 1'b1;
      S_START: if (tick) begin
        if (tx_s == OS_LAST) begin
          tx_state_n = S_DATA;
          tx_s_n     = '0;
        end else tx_s_n = tx_s + SW'(1);
      end
      S_DATA: if (tick) begin
        if (tx_s == OS_LAST) begin
          tx_s_n   = '0;
          tx_sh_n  = tx_sh >> 1;
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'(tx_dbits) + 3'd4) tx_state_n = tx_pen ? S_PAR : S_STOP;
        end else tx_s_n = tx_s + SW'(1);
      end
      S_PAR: if (tick) begin
        if (tx_s == OS_LAST) begin
          tx_state_n = S_STOP;
          tx_s_n     = '0;
        end else tx_s_n = tx_s + SW'(1);
      end
      S_STOP: if (tick) begin
        // Chain straight into the next START when more data is queued.
        if (tx_s == (tx_stop2 ? OS2_LAST : OS_LAST)) begin
          if (!txf_empty) tx_load = 1'b1;
          else            tx_state_n = S_IDLE;
        end else tx_s_n = tx_s + SW'(1);
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_n = S_START;
      tx_s_n     = '0;
      tx_bit_n   = '0;
      tx_sh_n    = head_masked;
      tx_pbit_n  = (^head_masked) ^ cfg_par[1];
      tx_dbits_n = cfg_dbits;
      tx_pen_n   = ^cfg_par;
      tx_stop2_n = cfg_stop2;
    end
    case (tx_state_n)
      S_START: tx_reg_n = 1'b0;
      S_DATA:  tx_reg_n = tx_sh_n[0];
      S_PAR:   tx_reg_n = tx_pbit_n;
      default: tx_reg_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_s     <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_pbit  <= 1'b0;
      tx_dbits <= 2'd3;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_reg   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_s     <= tx_s_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_pbit  <= tx_pbit_n;
      tx_dbits <= tx_dbits_n;
      tx_pen   <= tx_pen_n;
      tx_stop2 <= tx_stop2_n;
      tx_reg   <= tx_reg_n;
    end
  end

  assign tx_busy = (tx_state != S_IDLE) | ~txf_empty;

  // ---------------- pin muxing and RX synchroniser ----------------
  logic rx_src, rx_meta, rx_sync, rx_prev;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_reg : rx;
  assign tx     = loopback ? 1'b1 : tx_reg;
`else
  assign rx_src = rx;
  assign tx     = tx_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------- RX FSM ----------------
  logic [2:0]    rx_state;
  logic [SW-1:0] rx_s;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_pacc, rx_perr, rx_pen, rx_odd;
  logic [1:0]    rx_dbits;
  logic          rx_push;
  logic [9:0]    rx_word;

  assign rx_push = (rx_state == S_STOP) && tick && (rx_s == OS_LAST);
  // Bits arrive LSB first into the top of the shifter; right-align short frames.
  assign rx_word = {~rx_sync, rx_perr, rx_sh >> (2'd3 - rx_dbits)};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_s     <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pacc  <= 1'b0;
      rx_perr  <= 1'b0;
      rx_pen   <= 1'b0;
      rx_odd   <= 1'b0;
      rx_dbits <= 2'd3;
    end else begin
      case (rx_state)
        S_IDLE: if (rx_prev && !rx_sync) begin
          rx_state <= S_START;
          rx_s     <= '0;
          rx_bit   <= '0;
          rx_pacc  <= 1'b0;
          rx_perr  <= 1'b0;
          rx_dbits <= cfg_dbits;
          rx_pen   <= ^cfg_par;
          rx_odd   <= cfg_par[1];
        end
        S_START: if (tick) begin
          if (rx_s == OS_MID) begin
            rx_s     <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else rx_s <= rx_s + SW'(1);
        end
        S_DATA: if (tick) begin
          if (rx_s == OS_LAST) begin
            rx_s    <= '0;
            rx_sh   <= {rx_sync, rx_sh[7:1]};
            rx_pacc <= rx_pacc ^ rx_sync;
            rx_bit  <= rx_bit + 3'd1;
            if (rx_bit == 3'(rx_dbits) + 3'd4) rx_state <= rx_pen ? S_PAR : S_STOP;
          end else rx_s <= rx_s + SW'(1);
        end
        S_PAR: if (tick) begin
          if (rx_s == OS_LAST) begin
            rx_s     <= '0;
            rx_perr  <= rx_pacc ^ rx_sync ^ rx_odd;
            rx_state <= S_STOP;
          end else rx_s <= rx_s + SW'(1);
        end
        S_STOP: if (tick) begin
          if (rx_s == OS_LAST) rx_state <= S_IDLE;
          else                 rx_s <= rx_s + SW'(1);
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [9:0]         rxf_mem [DEPTH];
  logic [FIFO_AW-1:0] rxf_wp, rxf_rp;
  logic               rxf_full, rxf_wr_ok, rxf_rd_ok;
  logic [9:0]         rxf_head;

  assign rx_empty  = (rx_level == '0);
  assign rxf_full  = (rx_level == FULL_LVL);
  assign rxf_wr_ok = rx_push & ~rxf_full;
  assign rxf_rd_ok = rd_uart & ~rx_empty;
  assign rxf_head  = rxf_mem[rxf_rp];
  assign r_data    = rxf_head[7:0];
  assign r_err     = rxf_head[9:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      rxf_wp   <= '0;
      rxf_rp   <= '0;
      rx_level <= '0;
    end else begin
      if (rxf_wr_ok) rxf_wp <= rxf_wp + FIFO_AW'(1);
      if (rxf_rd_ok) rxf_rp <= rxf_rp + FIFO_AW'(1);
      if (rxf_wr_ok && !rxf_rd_ok)      rx_level <= rx_level + (FIFO_AW+1)'(1);
      else if (!rxf_wr_ok && rxf_rd_ok) rx_level <= rx_level - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rxf_wr_ok) rxf_mem[rxf_wp] <= rx_word;
  end

  // Set has priority over clear so a coincident overrun is never lost.
  always_ff @(posedge clk) begin
    if (reset)                    rx_overrun <= 1'b0;
    else if (rx_push && rxf_full) rx_overrun <= 1'b1;
    else if (clr_overrun)         rx_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: 4-deep FIFOs, dvsr=0 so every bit lasts 16 clocks.
module tb_uart_core_param;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [13:0]   dvsr = '0;
  logic [1:0]    cfg_dbits = 2'd3;
  logic [1:0]    cfg_par = 2'd0;
  logic          cfg_stop2 = 1'b0;
  logic          rx;
  logic          rd_uart = 1'b0;
  logic [7:0]    r_data;
  logic [1:0]    r_err;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          rx_overrun;
  logic          clr_overrun = 1'b0;
  logic [7:0]    w_data = '0;
  logic          wr_uart = 1'b0;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic          tx_busy;
  logic          tx;
  logic          loop_en = 1'b0;
  logic          rx_drv = 1'b1;

  int checks = 0;
  int passed = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_param #(.FIFO_AW(AW), .OVERSAMPLE(16), .DVSR_W(14)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .cfg_dbits(cfg_dbits), .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2), .rx(rx), .rd_uart(rd_uart), .r_data(r_data), .r_err(r_err),
    .rx_empty(rx_empty), .rx_level(rx_level), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun),
    .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .tx_level(tx_level),
    .tx_busy(tx_busy), .tx(tx)
  );

  task automatic write_byte(input logic [7:0] b);
    w_data = b; wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic wait_tx_fall(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (tx === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Serial frame on the rx pin, 16 clocks per bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pbit, input logic stopb);
    rx_drv = 1'b0; repeat (16) @(negedge clk);
    for (int i = 0; i < nb; i++) begin rx_drv = d[i]; repeat (16) @(negedge clk); end
    if (pen) begin rx_drv = pbit; repeat (16) @(negedge clk); end
    rx_drv = stopb; repeat (16) @(negedge clk);
    rx_drv = 1'b1; repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b exp 1", tx); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b exp 0", tx_busy); else passed++;
    checks++; if (rx_empty !== 1'b1) $display("FAIL reset_rx_empty: got %b exp 1", rx_empty); else passed++;
    checks++; if (tx_full !== 1'b0) $display("FAIL reset_tx_full: got %b exp 0", tx_full); else passed++;
    checks++; if (tx_level !== 3'd0 || rx_level !== 3'd0)
      $display("FAIL reset_levels: got tx %0d rx %0d exp 0 0", tx_level, rx_level); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun: got %b exp 0", rx_overrun); else passed++;
  endtask

  task automatic test_tx_8n1();
    logic [7:0] exp_b;
    bit ok;
    exp_b = 8'hA5;
    cfg_dbits = 2'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0;
    write_byte(exp_b);
    wait_tx_fall(4, ok);
    checks++; if (!ok) $display("FAIL tx_start_latency: tx still %b exp 0", tx); else passed++;
    repeat (7) @(negedge clk);
    checks++; if (tx !== 1'b0) $display("FAIL tx_start_bit: got %b exp 0", tx); else passed++;
    checks++; if (tx_busy !== 1'b1) $display("FAIL tx_busy_mid: got %b exp 1", tx_busy); else passed++;
    for (int k = 0; k < 8; k++) begin
      repeat (16) @(negedge clk);
      checks++; if (tx !== exp_b[k]) $display("FAIL tx_data_bit%0d: got %b exp %b", k, tx, exp_b[k]); else passed++;
    end
    repeat (16) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL tx_stop_bit: got %b exp 1", tx); else passed++;
    repeat (10) @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL tx_idle_after: got busy %b tx %b exp 0 1", tx_busy, tx); else passed++;
  endtask

  task automatic test_loop_7e2();
    bit ok;
    cfg_dbits = 2'd2; cfg_par = 2'b01; cfg_stop2 = 1'b1;
    loop_en = 1'b1;
    write_byte(8'h55);
    write_byte(8'h2A);
    wait_tx_fall(6, ok);
    checks++; if (!ok) $display("FAIL loop_tx_start: tx still %b exp 0", tx); else passed++;
    // 11-bit frame = 176 clocks; the second start must follow the second stop bit directly.
    repeat (167) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL loop_stop2: got %b exp 1", tx); else passed++;
    repeat (16) @(negedge clk);
    checks++; if (tx !== 1'b0) $display("FAIL loop_no_gap: got %b exp 0", tx); else passed++;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rx_level === 3'd2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) $display("FAIL loop_rx_level: got %0d exp 2", rx_level); else passed++;
    checks++; if (r_data !== 8'h55 || r_err !== 2'b00)
      $display("FAIL loop_byte0: got %h err %b exp 55 00", r_data, r_err); else passed++;
    pop_rx();
    checks++; if (r_data !== 8'h2A || r_err !== 2'b00)
      $display("FAIL loop_byte1: got %h err %b exp 2a 00", r_data, r_err); else passed++;
    pop_rx();
    checks++; if (rx_empty !== 1'b1) $display("FAIL loop_drained: got %b exp 1", rx_empty); else passed++;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) $display("FAIL loop_tx_done: busy %b exp 0", tx_busy); else passed++;
    loop_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_rx_errors();
    cfg_dbits = 2'd3; cfg_par = 2'b10; cfg_stop2 = 1'b0;
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1);  // odd parity of 0x00 needs 1
    checks++; if (r_data !== 8'h00 || r_err !== 2'b01)
      $display("FAIL rx_parity_err: got %h err %b exp 00 01", r_data, r_err); else passed++;
    pop_rx();
    send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0);
    checks++; if (r_data !== 8'h00 || r_err !== 2'b10)
      $display("FAIL rx_frame_err: got %h err %b exp 00 10", r_data, r_err); else passed++;
    pop_rx();
    cfg_dbits = 2'd0; cfg_par = 2'b00;
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1);
    checks++; if (r_data !== 8'h15 || r_err !== 2'b00)
      $display("FAIL rx_5n1: got %h err %b exp 15 00", r_data, r_err); else passed++;
    pop_rx();
    checks++; if (rx_empty !== 1'b1) $display("FAIL rx_err_drained: got %b exp 1", rx_empty); else passed++;
  endtask

  task automatic test_glitch();
    cfg_dbits = 2'd3; cfg_par = 2'b00;
    rx_drv = 1'b0; repeat (4) @(negedge clk);
    rx_drv = 1'b1; repeat (40) @(negedge clk);
    checks++; if (rx_empty !== 1'b1 || rx_level !== 3'd0)
      $display("FAIL glitch_rejected: got empty %b level %0d exp 1 0", rx_empty, rx_level); else passed++;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (r_data !== 8'h3C || r_err !== 2'b00)
      $display("FAIL glitch_recover: got %h err %b exp 3c 00", r_data, r_err); else passed++;
    pop_rx();
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 8, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_level !== 3'd4 || rx_overrun !== 1'b0)
      $display("FAIL ovr_full: got level %0d ovr %b exp 4 0", rx_level, rx_overrun); else passed++;
    send_frame(bytes[4], 8, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_level !== 3'd4 || rx_overrun !== 1'b1)
      $display("FAIL ovr_set: got level %0d ovr %b exp 4 1", rx_level, rx_overrun); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_data !== bytes[i] || r_err !== 2'b00)
        $display("FAIL ovr_byte%0d: got %h err %b exp %h 00", i, r_data, r_err, bytes[i]); else passed++;
      pop_rx();
    end
    checks++; if (rx_empty !== 1'b1 || rx_overrun !== 1'b1)
      $display("FAIL ovr_sticky: got empty %b ovr %b exp 1 1", rx_empty, rx_overrun); else passed++;
    clr_overrun = 1'b1; @(negedge clk); clr_overrun = 1'b0;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clear: got %b exp 0", rx_overrun); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    cfg_dbits = 2'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    write_byte(8'hDA); write_byte(8'hB7); write_byte(8'hC4); write_byte(8'hE1);
    wait_tx_fall(4, ok);
    checks++; if (!ok) $display("FAIL rst_tx_start: tx still %b exp 0", tx); else passed++;
    // 2nd frame 0xB7, bit3 = 0 sits at 64..80 clocks into that frame.
    repeat (231) @(negedge clk);
    checks++; if (tx !== 1'b0 || tx_busy !== 1'b1)
      $display("FAIL rst_pre: got tx %b busy %b exp 0 1", tx, tx_busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL rst_tx_high: got %b exp 1", tx); else passed++;
    checks++; if (tx_level !== 3'd0 || tx_busy !== 1'b0)
      $display("FAIL rst_tx_state: got level %0d busy %b exp 0 0", tx_level, tx_busy); else passed++;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL rst_fifo_lost: got tx %b busy %b exp 1 0", tx, tx_busy); else passed++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_tx_8n1();
    test_loop_7e2();
    test_rx_errors();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
